// File: rtl/viterbi_decoder.sv
// K=7 (133/171) hard-decision Viterbi decoder with register-exchange survivors, tail-terminated frames.
// Output starts TBLEN beats after frame start, one bit per beat; input stalls while the output register is held.
module viterbi_decoder #(
  parameter int TBLEN = 36,
  parameter int MW    = 8
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] s_axis_tdata,
  input  logic [1:0] s_axis_tuser,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic       m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast
);
  localparam int NS = 64;
  localparam int CW = $clog2(TBLEN + 1);
  localparam logic [CW-1:0] TB_C    = CW'(TBLEN);
  localparam logic [MW-1:0] PM_INIT = MW'(32);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic [TBLEN-1:0] fsr_q, fsr_d;
  logic [MW-1:0]    pm_q [NS];
  logic [MW-1:0]    pm_d [NS];
  logic [TBLEN-1:0] surv_q [NS];
  logic [TBLEN-1:0] surv_d [NS];
  logic [MW-1:0]    acs_pm [NS];
  logic [TBLEN-1:0] acs_surv [NS];
  logic [5:0]       best;
  logic             mdat_q, mdat_d;
  logic             mvld_q, mvld_d;
  logic             mlast_q, mlast_d;
  logic             slot;

  function automatic logic [1:0] branch_metric(input logic [5:0] p, input logic b,
                                               input logic [1:0] rx, input logic [1:0] er);
    logic e0, e1;
    e0 = b ^ p[4] ^ p[3] ^ p[1] ^ p[0];
    e1 = b ^ p[5] ^ p[4] ^ p[3] ^ p[0];
    return {1'b0, (rx[0] ^ e0) & ~er[0]} + {1'b0, (rx[1] ^ e1) & ~er[1]};
  endfunction

  // Add-compare-select for every next state; the sign of the wrapped difference decides, ties keep x=0.
  always_comb begin : acs
    logic [5:0]    ns, p0, p1;
    logic [MW-1:0] m0, m1, diff;
    ns = '0; p0 = '0; p1 = '0; m0 = '0; m1 = '0; diff = '0;
    for (int n = 0; n < NS; n++) begin
      ns   = 6'(n);
      p0   = {ns[4:0], 1'b0};
      p1   = {ns[4:0], 1'b1};
      m0   = pm_q[p0] + MW'(branch_metric(p0, ns[5], s_axis_tdata, s_axis_tuser));
      m1   = pm_q[p1] + MW'(branch_metric(p1, ns[5], s_axis_tdata, s_axis_tuser));
      diff = m1 - m0;
      acs_pm[n]   = diff[MW-1] ? m1 : m0;
      acs_surv[n] = {surv_q[diff[MW-1] ? p1 : p0][TBLEN-2:0], ns[5]};
    end
  end

  always_comb begin : find_best
    logic [MW-1:0] dv;
    dv   = '0;
    best = '0;
    for (int i = 1; i < NS; i++) begin
      dv = pm_q[i] - pm_q[best];
      if (dv[MW-1]) best = 6'(i);
    end
  end

  always_comb begin
    logic [CW-1:0] flen;
    flen          = '0;
    state_d       = state_q;
    count_d       = count_q;
    fcnt_d        = fcnt_q;
    fsr_d         = fsr_q;
    pm_d          = pm_q;
    surv_d        = surv_q;
    mdat_d        = mdat_q;
    mvld_d        = mvld_q;
    mlast_d       = mlast_q;
    s_axis_tready = 1'b0;
    slot          = ~mvld_q | m_axis_tready;
    if (mvld_q && m_axis_tready) mvld_d = 1'b0;
    case (state_q)
      RUN: begin
        s_axis_tready = slot;
        if (s_axis_tvalid && slot) begin
          pm_d   = acs_pm;
          surv_d = acs_surv;
          if (count_q == TB_C) begin
            mdat_d  = surv_q[best][TBLEN-1];
            mvld_d  = 1'b1;
            mlast_d = 1'b0;
          end else begin
            count_d = count_q + CW'(1);
          end
          if (s_axis_tlast) begin
            flen    = (count_q == TB_C) ? TB_C : count_q + CW'(1);
            fcnt_d  = flen;
            // Terminated frames end in state 0; align its oldest undelivered bit to the MSB.
            fsr_d   = acs_surv[0] << (TB_C - flen);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot && fcnt_q != '0) begin
          mdat_d  = fsr_q[TBLEN-1];
          mvld_d  = 1'b1;
          mlast_d = (fcnt_q == CW'(1));
          fsr_d   = fsr_q << 1;
          fcnt_d  = fcnt_q - CW'(1);
        end else if (fcnt_q == '0 && mvld_q && m_axis_tready && mlast_q) begin
          for (int i = 0; i < NS; i++) pm_d[i] = (i == 0) ? '0 : PM_INIT;
          count_d = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= RUN;
      count_q <= '0;
      fcnt_q  <= '0;
      fsr_q   <= '0;
      mdat_q  <= 1'b0;
      mvld_q  <= 1'b0;
      mlast_q <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fcnt_q  <= fcnt_d;
      fsr_q   <= fsr_d;
      mdat_q  <= mdat_d;
      mvld_q  <= mvld_d;
      mlast_q <= mlast_d;
      pm_q    <= pm_d;
      surv_q  <= surv_d;
    end
  end

  assign m_axis_tdata  = mdat_q;
  assign m_axis_tvalid = mvld_q;
  assign m_axis_tlast  = mlast_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Bench for viterbi_decoder: encodes random frames with the K=7 code and expects the source bits back.
module tb_viterbi_decoder;
  localparam int TBLEN = 36;
  localparam logic [6:0] G0 = 7'b1011011;
  localparam logic [6:0] G1 = 7'b1111001;

  logic       aclk;
  logic       aresetn;
  logic [1:0] s_axis_tdata;
  logic [1:0] s_axis_tuser;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;

  int         n_cmp;
  int         n_err;
  int         flen;
  logic       src [256];
  logic [1:0] cod [256];
  logic [1:0] ers [256];
  int         acc_cyc [256];

  viterbi_decoder #(.TBLEN(TBLEN), .MW(8)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rate-1/2 encoder from state 0; punct selects the 3/4 pattern (erase g1 on beat 1, g0 on beat 2 of each 3).
  task automatic make_frame(input int ndata, input int ntail, input bit zero_data, input bit punct);
    logic [6:0] win;
    win  = '0;
    flen = ndata + ntail;
    for (int i = 0; i < flen; i++) begin
      src[i] = (i < ndata && !zero_data) ? 1'($urandom_range(0, 1)) : 1'b0;
      win    = {src[i], win[6:1]};
      cod[i][0] = ^(win & G0);
      cod[i][1] = ^(win & G1);
      ers[i] = 2'b00;
      if (punct && (i % 3) == 1) begin
        ers[i]    = 2'b10;
        cod[i][1] = 1'($urandom_range(0, 1));
      end
      if (punct && (i % 3) == 2) begin
        ers[i]    = 2'b01;
        cod[i][0] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Drives one frame (or its first stop_after beats) and scores every output handshake.
  task automatic run_frame(input int stop_after, input bit rand_rdy, input bit check_lat, input string tag);
    int bi, ob, cyc, first_vld;
    bit flushing, done;
    bi = 0; ob = 0; cyc = 0; first_vld = -1; flushing = 0; done = 0;
    while (!done && cyc < 2000) begin
      @(negedge aclk);
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bi < flen) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = cod[bi];
        s_axis_tuser  = ers[bi];
        s_axis_tlast  = (bi == flen - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      #1;
      if (flushing) chk({tag, "_flush_s_tready"}, 32'(s_axis_tready), 0);
      if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
      if (s_axis_tvalid && s_axis_tready) begin
        acc_cyc[bi] = cyc;
        if (s_axis_tlast) flushing = 1;
        bi++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (ob < flen) begin
          chk($sformatf("%s_bit%0d", tag, ob), 32'(m_axis_tdata), 32'(src[ob]));
          chk($sformatf("%s_tlast%0d", tag, ob), 32'(m_axis_tlast), 32'(ob == flen - 1));
        end else begin
          chk({tag, "_extra_bit"}, 32'(ob), 32'(flen - 1));
        end
        ob++;
        if (m_axis_tlast) done = 1;
      end
      if (stop_after >= 0 && bi == stop_after) done = 1;
      cyc++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    if (stop_after < 0) begin
      chk({tag, "_count"}, 32'(ob), 32'(flen));
      if (check_lat) chk({tag, "_first_vld"}, 32'(first_vld), 32'(acc_cyc[TBLEN] + 1));
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      chk({tag, "_run_s_tready"}, 32'(s_axis_tready), 1);
      chk({tag, "_idle_tvalid"}, 32'(m_axis_tvalid), 0);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; flen = 0;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    chk("post_rst_s_tready", 32'(s_axis_tready), 1);

    // Error-free 48+6 frame, then the same frame with two coded-bit errors 20 beats apart.
    make_frame(48, 6, 0, 0);
    run_frame(-1, 0, 1, "t1");
    cod[10][0] = ~cod[10][0];
    cod[30][1] = ~cod[30][1];
    run_frame(-1, 0, 1, "t2");

    make_frame(90, 6, 0, 1);
    run_frame(-1, 0, 1, "t3");

    make_frame(4, 6, 1, 0);
    run_frame(-1, 0, 0, "t4");

    make_frame(0, 1, 1, 0);
    run_frame(-1, 0, 0, "t4b");

    make_frame(194, 6, 0, 0);
    run_frame(-1, 1, 0, "t5");

    // Abort frame A after 20 beats with a reset, then a clean frame B.
    make_frame(100, 6, 0, 0);
    run_frame(20, 0, 0, "t6a");
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    aresetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t6_rst_tvalid%0d", k), 32'(m_axis_tvalid), 0);
      chk($sformatf("t6_rst_tlast%0d", k), 32'(m_axis_tlast), 0);
      @(negedge aclk);
    end
    aresetn = 1'b1;
    make_frame(60, 6, 0, 0);
    run_frame(-1, 0, 1, "t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
